// File: rtl/fsm_juego_multi.sv
// Dice-game round controller: arms on MIN_PRESS held buttons, rolls on full
// release, waits for every dice engine to report done (or a cycle timeout),
// then pulses the win-evaluation enable and counts completed rounds.
module fsm_juego_multi #(
    parameter int unsigned NUM_BTN     = 2,
    parameter int unsigned NUM_DADOS   = 2,
    parameter int unsigned MIN_PRESS   = 2,
    parameter int unsigned TIMEOUT_CYC = 1000000,
    parameter int unsigned RONDA_W     = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NUM_BTN-1:0]   tirar_i,
    input  logic [NUM_DADOS-1:0] done_dados_i,
    output logic                 en_dados_o,
    output logic                 en_gane_o,
    output logic                 timeout_o,
    output logic                 busy_o,
    output logic [RONDA_W-1:0]   ronda_o,
    output logic [2:0]           estado_o
);

    localparam int unsigned CNT_W = $clog2(NUM_BTN + 1);
    localparam int unsigned TMR_W = (TIMEOUT_CYC == 0) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] MIN_P    = CNT_W'(MIN_PRESS);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
    localparam bit               TMO_EN   = (TIMEOUT_CYC != 0);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GOT_SOME = 3'd1,
        ARMED    = 3'd2,
        LET_SOME = 3'd3,
        TIRA     = 3'd4,
        EVALUA   = 3'd5
    } state_t;

    state_t               state, state_n;
    logic [CNT_W-1:0]     cnt;
    logic [NUM_DADOS-1:0] latch;
    logic [TMR_W-1:0]     timer;
    logic                 all_done;
    logic                 tmo_hit;

    // Number of buttons currently held
    always_comb begin
        cnt = '0;
        for (int unsigned i = 0; i < NUM_BTN; i++) begin
            cnt = cnt + CNT_W'(tirar_i[i]);
        end
    end

    // A done arriving in the current cycle counts together with the latched ones
    assign all_done = &(latch | done_dados_i);
    assign tmo_hit  = TMO_EN && (timer == TMR_LAST);

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic; unused codes fall back to IDLE
    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (cnt >= MIN_P)     state_n = ARMED;
                else if (cnt != '0)   state_n = GOT_SOME;
            end
            GOT_SOME: begin
                if (cnt == '0)        state_n = IDLE;
                else if (cnt >= MIN_P) state_n = ARMED;
            end
            ARMED: begin
                if (cnt == '0)        state_n = TIRA;
                else if (cnt < MIN_P) state_n = LET_SOME;
            end
            LET_SOME: begin
                if (cnt == '0)         state_n = TIRA;
                else if (cnt >= MIN_P) state_n = ARMED;
            end
            TIRA: begin
                if (all_done)         state_n = EVALUA;
                else if (tmo_hit)     state_n = IDLE;
            end
            EVALUA:                   state_n = IDLE;
            default:                  state_n = IDLE;
        endcase
    end

    // Roll datapath: done latches, roll timer, abort pulse and round counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            latch     <= '0;
            timer     <= '0;
            timeout_o <= 1'b0;
            ronda_o   <= '0;
        end else begin
            timeout_o <= (state == TIRA) && !all_done && tmo_hit;
            if (state == EVALUA) begin
                ronda_o <= ronda_o + RONDA_W'(1);
            end
            if ((state != TIRA) && (state_n == TIRA)) begin
                latch <= '0;
                timer <= '0;
            end else if (state == TIRA) begin
                latch <= latch | done_dados_i;
                timer <= timer + TMR_W'(1);
            end
        end
    end

    assign en_dados_o = (state == TIRA);
    assign en_gane_o  = (state == EVALUA);
    assign busy_o     = (state == TIRA) || (state == EVALUA);
    assign estado_o   = state;

endmodule

// File: tb/tb_fsm_juego_multi.sv
// Bench for fsm_juego_multi: unit A (2 buttons, 2 dice, timeout 8, 2-bit
// round counter) and unit B (4 buttons, MIN_PRESS 3, timeout disabled).
module tb_fsm_juego_multi;

    localparam logic [2:0] S_I = 3'd0;
    localparam logic [2:0] S_G = 3'd1;
    localparam logic [2:0] S_A = 3'd2;
    localparam logic [2:0] S_L = 3'd3;
    localparam logic [2:0] S_T = 3'd4;
    localparam logic [2:0] S_E = 3'd5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Unit A
    logic       rst_a = 1'b1;
    logic [1:0] tirar_a = '0;
    logic [1:0] done_a = '0;
    logic       en_dados_a, en_gane_a, timeout_a, busy_a;
    logic [1:0] ronda_a;
    logic [2:0] estado_a;

    // Unit B
    logic       rst_b = 1'b1;
    logic [3:0] tirar_b = '0;
    logic [1:0] done_b = '0;
    logic       en_dados_b, en_gane_b, timeout_b, busy_b;
    logic [7:0] ronda_b;
    logic [2:0] estado_b;

    fsm_juego_multi #(
        .NUM_BTN(2), .NUM_DADOS(2), .MIN_PRESS(2), .TIMEOUT_CYC(8), .RONDA_W(2)
    ) dut_a (
        .clk_i(clk), .rst_i(rst_a), .tirar_i(tirar_a), .done_dados_i(done_a),
        .en_dados_o(en_dados_a), .en_gane_o(en_gane_a), .timeout_o(timeout_a),
        .busy_o(busy_a), .ronda_o(ronda_a), .estado_o(estado_a)
    );

    fsm_juego_multi #(
        .NUM_BTN(4), .NUM_DADOS(2), .MIN_PRESS(3), .TIMEOUT_CYC(0), .RONDA_W(8)
    ) dut_b (
        .clk_i(clk), .rst_i(rst_b), .tirar_i(tirar_b), .done_dados_i(done_b),
        .en_dados_o(en_dados_b), .en_gane_o(en_gane_b), .timeout_o(timeout_b),
        .busy_o(busy_b), .ronda_o(ronda_b), .estado_o(estado_b)
    );

    typedef struct {
        bit         u;
        logic [2:0] st;
        logic       to;
        logic [7:0] ronda;
        int         id;
    } exp_t;

    exp_t q[$];
    int tests = 0;
    int fails = 0;
    int vec_id = 0;

    task automatic step_a(input bit r, input logic [1:0] t, input logic [1:0] d,
                          input logic [2:0] st, input logic to, input logic [7:0] ro);
        exp_t e;
        @(negedge clk);
        rst_a = r; tirar_a = t; done_a = d;
        e.u = 1'b0; e.st = st; e.to = to; e.ronda = ro; e.id = vec_id;
        q.push_back(e);
        vec_id++;
    endtask

    task automatic step_b(input bit r, input logic [3:0] t, input logic [1:0] d,
                          input logic [2:0] st, input logic to, input logic [7:0] ro);
        exp_t e;
        @(negedge clk);
        rst_b = r; tirar_b = t; done_b = d;
        e.u = 1'b1; e.st = st; e.to = to; e.ronda = ro; e.id = vec_id;
        q.push_back(e);
        vec_id++;
    endtask

    // Monitor: after every edge, compare the selected unit against the oldest expectation
    initial begin
        exp_t e;
        logic [2:0] ast;
        logic       ad, ag, ab, at;
        logic [7:0] ar;
        logic       wd, wg, wb;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                if (e.u) begin
                    ast = estado_b; ad = en_dados_b; ag = en_gane_b; ab = busy_b;
                    at = timeout_b; ar = ronda_b;
                end else begin
                    ast = estado_a; ad = en_dados_a; ag = en_gane_a; ab = busy_a;
                    at = timeout_a; ar = {6'b0, ronda_a};
                end
                wd = (e.st == S_T);
                wg = (e.st == S_E);
                wb = (e.st == S_T) || (e.st == S_E);
                tests++;
                if (ast !== e.st || ad !== wd || ag !== wg || ab !== wb ||
                    at !== e.to || ar !== e.ronda) begin
                    fails++;
                    $display("FAIL vec%0d unit%0d: got st=%0d dados=%b gane=%b busy=%b to=%b ronda=%0d, want st=%0d dados=%b gane=%b busy=%b to=%b ronda=%0d",
                             e.id, e.u, ast, ad, ag, ab, at, ar,
                             e.st, wd, wg, wb, e.to, e.ronda);
                end
            end
        end
    end

    // Directed stimulus
    initial begin
        // Reset
        step_a(1, 2'b00, 2'b00, S_I, 0, 0);
        step_a(1, 2'b00, 2'b00, S_I, 0, 0);

        // Arm with 11, partial release, full release, done on 5th TIRA cycle
        for (int i = 0; i < 3; i++) step_a(0, 2'b11, 2'b00, S_A, 0, 0);
        for (int i = 0; i < 2; i++) step_a(0, 2'b01, 2'b00, S_L, 0, 0);
        step_a(0, 2'b00, 2'b00, S_T, 0, 0);
        step_a(0, 2'b00, 2'b00, S_T, 0, 0);
        step_a(0, 2'b11, 2'b00, S_T, 0, 0);
        step_a(0, 2'b00, 2'b00, S_T, 0, 0);
        step_a(0, 2'b00, 2'b00, S_T, 0, 0);
        step_a(0, 2'b00, 2'b11, S_E, 0, 0);
        step_a(0, 2'b00, 2'b00, S_I, 0, 1);

        // Single button never arms
        step_a(0, 2'b01, 2'b00, S_G, 0, 1);
        step_a(0, 2'b01, 2'b00, S_G, 0, 1);
        step_a(0, 2'b00, 2'b00, S_I, 0, 1);
        step_a(0, 2'b00, 2'b00, S_I, 0, 1);

        // Non-overlapping done pulses are latched
        step_a(0, 2'b11, 2'b00, S_A, 0, 1);
        step_a(0, 2'b00, 2'b00, S_T, 0, 1);
        step_a(0, 2'b00, 2'b00, S_T, 0, 1);
        step_a(0, 2'b00, 2'b01, S_T, 0, 1);
        for (int i = 0; i < 3; i++) step_a(0, 2'b00, 2'b00, S_T, 0, 1);
        step_a(0, 2'b00, 2'b10, S_E, 0, 1);
        step_a(0, 2'b00, 2'b00, S_I, 0, 2);

        // Timeout: only die 0 done, 8 TIRA cycles then abort pulse
        step_a(0, 2'b11, 2'b00, S_A, 0, 2);
        step_a(0, 2'b00, 2'b00, S_T, 0, 2);
        for (int i = 0; i < 7; i++) step_a(0, 2'b00, 2'b01, S_T, 0, 2);
        step_a(0, 2'b00, 2'b01, S_I, 1, 2);
        step_a(0, 2'b00, 2'b00, S_I, 0, 2);

        // All done on the 8th cycle wins over timeout
        step_a(0, 2'b11, 2'b00, S_A, 0, 2);
        step_a(0, 2'b00, 2'b00, S_T, 0, 2);
        for (int i = 0; i < 7; i++) step_a(0, 2'b00, 2'b00, S_T, 0, 2);
        step_a(0, 2'b00, 2'b11, S_E, 0, 2);
        step_a(0, 2'b00, 2'b00, S_I, 0, 3);

        // Minimum roll (1 cycle), counter wrap, held button re-arms
        step_a(0, 2'b11, 2'b00, S_A, 0, 3);
        step_a(0, 2'b00, 2'b00, S_T, 0, 3);
        step_a(0, 2'b00, 2'b11, S_E, 0, 3);
        step_a(0, 2'b11, 2'b00, S_I, 0, 0);
        step_a(0, 2'b11, 2'b00, S_A, 0, 0);
        step_a(0, 2'b00, 2'b00, S_T, 0, 0);
        step_a(0, 2'b00, 2'b01, S_T, 0, 0);
        step_a(0, 2'b00, 2'b10, S_E, 0, 0);
        step_a(0, 2'b00, 2'b00, S_I, 0, 1);

        // Reset mid-roll clears round count and latches
        step_a(0, 2'b11, 2'b00, S_A, 0, 1);
        step_a(0, 2'b00, 2'b00, S_T, 0, 1);
        step_a(0, 2'b00, 2'b01, S_T, 0, 1);
        step_a(1, 2'b00, 2'b00, S_I, 0, 0);
        step_a(0, 2'b11, 2'b00, S_A, 0, 0);
        step_a(0, 2'b00, 2'b00, S_T, 0, 0);
        step_a(0, 2'b00, 2'b10, S_T, 0, 0);
        step_a(0, 2'b00, 2'b01, S_E, 0, 0);
        step_a(0, 2'b00, 2'b00, S_I, 0, 1);

        // Unit B: 4 buttons, MIN_PRESS 3, no timeout
        step_b(1, 4'b0000, 2'b00, S_I, 0, 0);
        step_b(1, 4'b0000, 2'b00, S_I, 0, 0);
        step_b(0, 4'b0011, 2'b00, S_G, 0, 0);
        step_b(0, 4'b0011, 2'b00, S_G, 0, 0);
        step_b(0, 4'b0111, 2'b00, S_A, 0, 0);
        step_b(0, 4'b0001, 2'b00, S_L, 0, 0);
        step_b(0, 4'b0001, 2'b00, S_L, 0, 0);
        step_b(0, 4'b1011, 2'b00, S_A, 0, 0);
        step_b(0, 4'b0000, 2'b00, S_T, 0, 0);
        for (int i = 0; i < 12; i++) step_b(0, 4'b0000, 2'b00, S_T, 0, 0);
        step_b(0, 4'b0000, 2'b11, S_E, 0, 0);
        step_b(0, 4'b0000, 2'b00, S_I, 0, 1);

        // Let the monitor drain the queue, bounded
        for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
        #2;
        if (q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fsm_juego_multi.md
Name: fsm_juego_multi

Overview:
Parametrised dice-game round controller for N player buttons and M dice engines. It arms when at least MIN_PRESS buttons are held, and launches a roll once all buttons are released. It enables the dice engines until each one reports done, then pulses the win-evaluation enable and counts rounds. A cycle timeout aborts a roll if any die never reports done.

Parameters:
NUM_BTN, 2, number of player buttons (>=1)
NUM_DADOS, 2, number of dice engines (>=1)
MIN_PRESS, 2, buttons held simultaneously to arm a roll (1..NUM_BTN)
TIMEOUT_CYC, 1000000, max cycles in TIRA before abort; 0 disables timeout
RONDA_W, 8, width of round counter

Ports:
clk_i  in  1  system clock, all logic on rising edge
rst_i  in  1  synchronous reset, active-high
tirar_i  in  NUM_BTN  button levels, 1 = pressed; synchronised/debounced upstream
done_dados_i  in  NUM_DADOS  per-die done; level or 1-cycle pulse accepted
en_dados_o  out  1  dice enable, high in every TIRA cycle
en_gane_o  out  1  win-evaluation enable, 1-cycle pulse
timeout_o  out  1  1-cycle pulse on roll abort
busy_o  out  1  high in TIRA or EVALUA
ronda_o  out  RONDA_W  completed-round count
estado_o  out  3  current state code, debug

Behaviour:
- Reset (rst_i=1 at an edge, from any state, mid-roll included): state=IDLE, ronda_o=0, timer=0, done latches=0, timeout_o=0. Decoded outputs follow IDLE, so en_dados_o=0, en_gane_o=0, busy_o=0.
- State encoding: IDLE=0, GOT_SOME=1, ARMED=2, LET_SOME=3, TIRA=4, EVALUA=5. Codes 6-7 go to IDLE on the next edge.
- cnt = popcount(tirar_i), computed combinationally with width $clog2(NUM_BTN+1).
- IDLE: cnt=0 stays; 0<cnt<MIN_PRESS goes to GOT_SOME; cnt>=MIN_PRESS goes to ARMED.
- GOT_SOME: cnt=0 goes to IDLE; cnt<MIN_PRESS stays; cnt>=MIN_PRESS goes to ARMED.
- ARMED: cnt>=MIN_PRESS stays; 0<cnt<MIN_PRESS goes to LET_SOME; cnt=0 goes to TIRA.
- LET_SOME: cnt=0 goes to TIRA; cnt>=MIN_PRESS goes to ARMED; otherwise stays.
- Entering TIRA clears the done latches and sets timer=0.
- TIRA, each cycle:
  - latch[i] |= done_dados_i[i]; timer increments.
  - all_done = &(latch | done_dados_i), so a done arriving this cycle counts.
  - all_done=1 goes to EVALUA; this takes priority over timeout on the same cycle.
  - Otherwise, if TIMEOUT_CYC!=0 and timer==TIMEOUT_CYC-1, go to IDLE and set timeout_o=1 for the following cycle only.
  - Buttons are ignored.
- EVALUA: exactly one cycle, then IDLE. ronda_o increments at the edge leaving EVALUA and wraps modulo 2^RONDA_W. Buttons are ignored.
- Outputs and latency:
  - en_dados_o, en_gane_o and busy_o are combinational decodes of the state register (Moore, glitch-free).
  - timeout_o and ronda_o are registered.
  - en_dados_o first rises the cycle after the edge where cnt became 0 in ARMED/LET_SOME.
  - en_gane_o rises the cycle after all_done is seen.
- Roll-length bounds: minimum TIRA occupancy is 1 cycle (all done already high). With timeout, maximum is TIMEOUT_CYC cycles.
- Aborted rolls do not increment ronda_o and never assert en_gane_o.
- A button still held when returning to IDLE is handled by the normal IDLE rules, so a held button re-arms.
- Timer width: $clog2(TIMEOUT_CYC+1), minimum 1 bit.

Test Plan:
- Defaults, tirar_i 00->11 (3 cyc)->01 (2 cyc)->00: states IDLE->ARMED->LET_SOME->TIRA; en_dados_o high from the cycle after 00. done=11 on the 5th TIRA cycle gives en_gane_o for 1 cycle, then ronda_o=1 in IDLE.
- Defaults, tirar_i 01 then 00 (never 11): states GOT_SOME->IDLE; en_dados_o never asserts.
- Defaults in TIRA, done_dados_i pulses 01 at cycle 2 and 10 at cycle 6 (non-overlapping): latches hold, EVALUA entered after cycle 6, en_gane_o pulses once.
- TIMEOUT_CYC=8, only die 0 done: exactly 8 en_dados_o cycles, then timeout_o for 1 cycle, state IDLE, en_gane_o=0, ronda_o unchanged. Variant with done=11 on cycle 8 gives EVALUA, no timeout.
- NUM_BTN=4, MIN_PRESS=3: 0011 stays in GOT_SOME; 0111 goes to ARMED; 0001 goes to LET_SOME; 1011 returns to ARMED; 0000 goes to TIRA.
- RONDA_W=2: 4 complete rounds give ronda_o 1,2,3,0. rst_i=1 mid-TIRA gives IDLE next cycle, all outputs 0 and latches cleared, so the next roll needs fresh done pulses.
